// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte/word helpers for the round
// sequencer and its S-box.
package aes_pkg;

  localparam int         NR_AES128 = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } aes_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8)
// (computed as x^254) followed by the FIPS-197 affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 = x^(2+4+...+128); zero maps to zero as the S-box requires.
  function automatic byte_t gf_inv(input byte_t x);
    byte_t sq;
    byte_t r;
    sq = x;
    r  = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic byte_t affine(input byte_t b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign out_o = affine(gf_inv(in_i));

endmodule

// File: rtl/aes_round_sched.sv
// Iterative AES-128 sequencer: initial AddRoundKey, 10 rounds through an
// external combinational round datapath, on-the-fly key expansion.
// Optional completion counter enabled by defining AES_BLK_CNT_EN.
module aes_round_sched
  import aes_pkg::*;
#(
  parameter int NR    = NR_AES128,
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   plain_text,
  input  logic [127:0]   key,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   cipher_text,
  output logic           busy,
  output logic [3:0]     round_idx,
  output logic [127:0]   rnd_state_o,
  output logic [127:0]   rnd_key_o,
  output logic           rnd_final_o,
  input  logic [127:0]   rnd_result_i
`ifdef AES_BLK_CNT_EN
  ,
  output logic [CNT_W-1:0] blk_count
`endif
);

  if (NR != NR_AES128 || CNT_W < 1) begin : g_bad_cfg
    $error("aes_round_sched: only NR=10 and CNT_W>=1 are supported");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  aes_state_e    fsm_q, fsm_d;
  logic [127:0]  state_q, state_d;
  logic [127:0]  key_q, key_d;
  byte_t         rcon_q, rcon_d;
  logic [3:0]    round_q, round_d;

  word_t         rot_w, sub_w, t_w;
  word_t         nk0, nk1, nk2, nk3;
  logic [127:0]  next_key;
  logic          in_round, in_done;

  // Next round key from the current one: one SubWord per round.
  assign rot_w = rot_word(key_q[31:0]);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot_w[8*i +: 8]),
      .out_o (sub_w[8*i +: 8])
    );
  end

  assign t_w      = sub_w ^ {rcon_q, 24'h0};
  assign nk0      = key_q[127:96] ^ t_w;
  assign nk1      = key_q[95:64]  ^ nk0;
  assign nk2      = key_q[63:32]  ^ nk1;
  assign nk3      = key_q[31:0]   ^ nk2;
  assign next_key = {nk0, nk1, nk2, nk3};

  assign in_round    = (fsm_q == ST_ROUND);
  assign in_done     = (fsm_q == ST_DONE);
  // Gated with reset so the source never sees ready while the block is held.
  assign in_ready    = (fsm_q == ST_IDLE) && reset;
  assign out_valid   = in_done;
  assign cipher_text = in_done ? state_q : '0;
  assign busy        = in_round;
  assign round_idx   = in_round ? round_q : 4'd0;
  assign rnd_state_o = state_q;
  assign rnd_key_o   = in_round ? next_key : '0;
  assign rnd_final_o = in_round && (round_q == NR_L);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    unique case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = plain_text ^ key;
          key_d   = key;
          rcon_d  = RCON_INIT;
          round_d = 4'd1;
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = rnd_result_i;
        key_d   = next_key;
        rcon_d  = xtime(rcon_q);
        round_d = round_q + 4'd1;
        if (round_q == NR_L) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      rcon_q  <= RCON_INIT;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
    end
  end

`ifdef AES_BLK_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign blk_count = cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: supplies the round datapath and checks every
// cycle against a table-driven AES-128 model plus FIPS-197 literal vectors.
module tb_aes_round_sched;

  typedef logic [127:0] blk_t;
  typedef blk_t rk_arr_t [0:10];
  typedef blk_t st_arr_t [0:11];

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain_text;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cipher_text;
  logic         busy;
  logic [3:0]   round_idx;
  logic [127:0] rnd_state_o;
  logic [127:0] rnd_key_o;
  logic         rnd_final_o;
  logic [127:0] rnd_result;
`ifdef AES_BLK_CNT_EN
  logic [31:0]  blk_count;
`endif

  aes_round_sched dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .plain_text   (plain_text),
    .key          (key),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .cipher_text  (cipher_text),
    .busy         (busy),
    .round_idx    (round_idx),
    .rnd_state_o  (rnd_state_o),
    .rnd_key_o    (rnd_key_o),
    .rnd_final_o  (rnd_final_o),
    .rnd_result_i (rnd_result)
`ifdef AES_BLK_CNT_EN
    ,
    .blk_count    (blk_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- AES reference (byte-array level) ----------------
  logic [7:0] sbt [0:255];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
  endfunction

  function automatic rk_arr_t key_sched(input blk_t k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rk_arr_t     rks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rks;
  endfunction

  function automatic blk_t aes_round(input blk_t s, input blk_t k, input logic last);
    logic [7:0] b [0:15];
    logic [7:0] n [0:15];
    logic [7:0] a0, a1, a2, a3;
    blk_t       o;
    for (int i = 0; i < 16; i++) b[i] = sbt[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) n[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
        n[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
        n[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
        n[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
        n[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = n[i];
    return o ^ k;
  endfunction

  // Index r (1..10) = state entering round r; index 11 = ciphertext.
  function automatic st_arr_t enc_states(input blk_t pt, input blk_t k);
    rk_arr_t rks;
    st_arr_t st;
    blk_t    s;
    rks   = key_sched(k);
    s     = pt ^ rks[0];
    st[0] = '0;
    st[1] = s;
    for (int r = 1; r <= 10; r++) begin
      s       = aes_round(s, rks[r], r == 10);
      st[r+1] = s;
    end
    return st;
  endfunction

  // External round datapath driven by the DUT.
  always @(rnd_state_o or rnd_key_o or rnd_final_o)
    rnd_result = aes_round(rnd_state_o, rnd_key_o, rnd_final_o);

  // ---------------- transaction-level expectation tracker ----------------
  int          m_phase = 0;   // 0 idle, 1..10 round r, 11 result pending
  rk_arr_t     m_rks;
  st_arr_t     m_sts;
  logic [31:0] m_blk = '0;
  int          cyc = 0, acc_cnt = 0, hs_cnt = 0, acc_cyc = 0, acc_prev = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0;
      m_blk   <= '0;
    end else begin
      cyc <= cyc + 1;
      if (m_phase == 0) begin
        if (in_valid) begin
          m_phase  <= 1;
          m_rks    <= key_sched(key);
          m_sts    <= enc_states(plain_text, key);
          acc_cnt  <= acc_cnt + 1;
          acc_prev <= acc_cyc;
          acc_cyc  <= cyc;
        end
      end else if (m_phase <= 10) begin
        m_phase <= m_phase + 1;
      end else if (out_ready) begin
        m_phase <= 0;
        hs_cnt  <= hs_cnt + 1;
        m_blk   <= m_blk + 32'd1;
      end
    end
  end

  task automatic chk(input string nm, input blk_t act, input blk_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic check_cycle();
    if (!reset) begin
      chk("rst_in_ready",  128'(in_ready),    128'(0));
      chk("rst_out_valid", 128'(out_valid),   128'(0));
      chk("rst_busy",      128'(busy),        128'(0));
      chk("rst_round_idx", 128'(round_idx),   128'(0));
      chk("rst_final",     128'(rnd_final_o), 128'(0));
      chk("rst_cipher",    cipher_text,       '0);
      chk("rst_rnd_state", rnd_state_o,       '0);
      chk("rst_rnd_key",   rnd_key_o,         '0);
    end else if (m_phase == 0) begin
      chk("idle_in_ready",  128'(in_ready),  128'(1));
      chk("idle_out_valid", 128'(out_valid), 128'(0));
      chk("idle_busy",      128'(busy),      128'(0));
      chk("idle_round_idx", 128'(round_idx), 128'(0));
      chk("idle_state_x",   128'($isunknown(rnd_state_o)), 128'(0));
    end else if (m_phase <= 10) begin
      chk("rnd_in_ready",  128'(in_ready),    128'(0));
      chk("rnd_out_valid", 128'(out_valid),   128'(0));
      chk("rnd_busy",      128'(busy),        128'(1));
      chk("rnd_round_idx", 128'(round_idx),   128'(m_phase));
      chk("rnd_state",     rnd_state_o,       m_sts[m_phase]);
      chk("rnd_key",       rnd_key_o,         m_rks[m_phase]);
      chk("rnd_final",     128'(rnd_final_o), 128'(m_phase == 10));
    end else begin
      chk("done_in_ready",  128'(in_ready),  128'(0));
      chk("done_out_valid", 128'(out_valid), 128'(1));
      chk("done_busy",      128'(busy),      128'(0));
      chk("done_round_idx", 128'(round_idx), 128'(0));
      chk("done_cipher",    cipher_text,     m_sts[11]);
    end
`ifdef AES_BLK_CNT_EN
    chk("blk_count", 128'(blk_count), 128'(m_blk));
`endif
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    #1;
  endtask

  task automatic send(input blk_t pt, input blk_t k, input bit keep);
    int start;
    start      = acc_cnt;
    in_valid   = 1'b1;
    plain_text = pt;
    key        = k;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (acc_cnt != start) break;
    end
    chk("accept_seen", 128'(acc_cnt != start), 128'(1));
    if (!keep) in_valid = 1'b0;
  endtask

  // Called right after send(): follows the block to out_valid.
  task automatic run_block(output int lat, output blk_t rk1, output blk_t rk10,
                           output logic fin10, output blk_t ct);
    lat   = 1;
    rk1   = rnd_key_o;
    rk10  = '0;
    fin10 = 1'b0;
    ct    = '0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) break;
      if (round_idx == 4'd10) begin
        rk10  = rnd_key_o;
        fin10 = rnd_final_o;
      end
      tick();
      lat++;
    end
    chk("out_valid_seen", 128'(out_valid), 128'(1));
    ct = cipher_text;
  endtask

  localparam blk_t K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam blk_t P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam blk_t C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam blk_t K_C  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam blk_t P_C  = 128'h00112233445566778899aabbccddeeff;
  localparam blk_t C_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam blk_t RK1B = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam blk_t RKAB = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam blk_t RKZ  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  initial begin
    int      lat;
    blk_t    rk1, rk10, ct;
    logic    fin10;
    rk_arr_t rks;
    st_arr_t sts;
    int      hs0;

    build_sbox();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    plain_text = '0; key = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Pin the reference model to published FIPS-197 values.
    rks = key_sched(K_B);
    chk("model_rk1_B",  rks[1],  RK1B);
    chk("model_rk10_B", rks[10], RKAB);
    sts = enc_states(P_B, K_B);
    chk("model_ct_B",   sts[11], C_B);
    sts = enc_states(P_C, K_C);
    chk("model_ct_C1",  sts[11], C_C);
    rks = key_sched('0);
    chk("model_rk10_zero", rks[10], RKZ);

    // App. B vector with latency and round-key probes.
    out_ready = 1'b1;
    send(P_B, K_B, 1'b0);
    run_block(lat, rk1, rk10, fin10, ct);
    chk("appB_latency", 128'(lat), 128'(11));
    chk("appB_rk1",     rk1,  RK1B);
    chk("appB_rk10",    rk10, RKAB);
    chk("appB_final10", 128'(fin10), 128'(1));
    chk("appB_cipher",  ct,   C_B);
    tick();

    // C.1 vector.
    send(P_C, K_C, 1'b0);
    run_block(lat, rk1, rk10, fin10, ct);
    chk("c1_cipher", ct, C_C);
    tick();

    // All-zero key: final round key exercises the rcon 0x80 -> 0x1b wrap.
    send('0, '0, 1'b0);
    run_block(lat, rk1, rk10, fin10, ct);
    chk("zero_rk10", rk10, RKZ);
    tick();

    // Backpressure: result must hold for 20 cycles, then release.
    out_ready = 1'b0;
    send(P_B, K_B, 1'b0);
    run_block(lat, rk1, rk10, fin10, ct);
    repeat (20) tick();
    chk("bp_in_ready",  128'(in_ready),  128'(0));
    chk("bp_cipher",    cipher_text,     C_B);
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", 128'(in_ready), 128'(1));

    // Back-to-back with in_valid and out_ready held high.
    send(P_C, K_C, 1'b1);
    send(P_B, K_B, 1'b0);
    chk("b2b_gap", 128'(acc_cyc - acc_prev), 128'(12));
    run_block(lat, rk1, rk10, fin10, ct);
    chk("b2b_cipher2", ct, C_B);
    tick();

    // Asynchronous abort during round 5, then a clean re-run.
    send(P_B, K_B, 1'b0);
    repeat (4) tick();
    chk("abort_at_round5", 128'(round_idx), 128'(5));
    #1 reset = 1'b0;
    #1 check_cycle();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    send(P_B, K_B, 1'b0);
    run_block(lat, rk1, rk10, fin10, ct);
    chk("rerun_cipher", ct, C_B);
    tick();

    // Random vectors with random idle gaps and random backpressure.
    for (int n = 0; n < 25; n++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      hs0 = hs_cnt;
      send({$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      for (int i = 0; i < 200; i++) begin
        if (hs_cnt != hs0) break;
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      chk("rand_handshake", 128'(hs_cnt != hs0), 128'(1));
    end
    out_ready = 1'b1;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
